// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for an RV32 datapath: FETCH/DECODE/EXEC/MEM/WB,
// with retired-instruction counting and halt on system instruction, illegal opcode or memory timeout.
module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  state,
  output logic        halted,
  output logic [1:0]  err_code,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    C_ALU, C_UIMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR
  } class_e;

  typedef enum logic [1:0] {
    E_NONE     = 2'b00,
    E_ILLEGAL  = 2'b01,
    E_IMEM_TO  = 2'b10,
    E_DMEM_TO  = 2'b11
  } err_e;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;
  localparam logic [1:0] PC_JALR   = 2'b11;

  // The wait counter never exceeds MEM_TIMEOUT-1, so it only needs that range.
  localparam int unsigned CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  state_e         state_q, state_d;
  class_e         class_q, class_d;
  err_e           err_q, err_d;
  logic [CW-1:0]  wait_q, wait_d;
  logic [31:0]    instret_q, instret_d;

  class_e dec_class;
  logic   dec_ok;
  logic   dec_sys;
  logic   retire_sys;
  logic   timeout_hit;

  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    dec_class = C_ALU;
    dec_ok    = 1'b1;
    dec_sys   = 1'b0;
    case (opcode)
      7'b0000011: dec_class = C_LOAD;
      7'b0100011: dec_class = C_STORE;
      7'b1100011: dec_class = C_BRANCH;
      7'b1101111: dec_class = C_JAL;
      7'b1100111: dec_class = C_JALR;
      7'b0110011,
      7'b0010011: dec_class = C_ALU;
      7'b0110111,
      7'b0010111: dec_class = C_UIMM;
      7'b1110011: begin
        dec_ok  = 1'b0;
        dec_sys = (funct3 == 3'b000);
      end
      default:    dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    err_d      = err_q;
    wait_d     = '0;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = PC_PLUS4;
    retire_sys = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_HALT;
          err_d   = E_IMEM_TO;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      S_DECODE: begin
        class_d = dec_class;
        if (dec_ok) begin
          state_d = S_EXEC;
        end else if (dec_sys) begin
          state_d    = S_HALT;
          retire_sys = 1'b1;
        end else begin
          state_d = S_HALT;
          err_d   = E_ILLEGAL;
        end
      end
      S_EXEC: begin
        case (class_q)
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken ? PC_BRANCH : PC_PLUS4;
            state_d = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (class_q == C_STORE);
        if (dmem_ready) begin
          if (class_q == C_STORE) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          state_d = S_HALT;
          err_d   = E_DMEM_TO;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = (class_q == C_JAL)  ? PC_JAL  :
                  (class_q == C_JALR) ? PC_JALR : PC_PLUS4;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign instret_d = instret_q + {31'd0, (pc_we | retire_sys)};

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      class_q   <= C_ALU;
      err_q     <= E_NONE;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      err_q     <= err_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  assign state    = state_q;
  assign halted   = (state_q == S_HALT);
  assign err_code = err_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench: an instruction-level model expands each instruction into its expected
// per-cycle trace; one player drives stimulus and compares every cycle, plus literal pins.
module tb_multicycle_sequencer;

  localparam int unsigned TO = 4;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6;

  localparam logic [6:0] OP_ADDI = 7'b0010011, OP_ALU = 7'b0110011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_SYS = 7'b1110011;

  localparam int K_ILL = 0, K_SYS = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5,
                 K_JALR = 6, K_OTHER = 7;

  logic clk = 1'b1;
  logic rst, start, imem_ready, dmem_ready, branch_taken;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halted;
  logic [1:0] pc_sel, err_code;
  logic [2:0] state;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multicycle_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .opcode(opcode), .funct3(funct3), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .state(state), .halted(halted),
    .err_code(err_code), .instret(instret)
  );

  typedef struct {
    bit rst, start, imem_ready, dmem_ready, bt;
    logic [6:0] op;
    logic [2:0] f3;
  } stim_t;

  typedef struct {
    logic [2:0] state;
    bit ireq, irwe, dreq, dwe, rfwe, pcwe;
    logic [1:0] psel;
    bit halted;
    logic [1:0] err;
    logic [31:0] instret;
    bit chk;
  } exp_t;

  stim_t s_cur;
  stim_t stim_q[$];
  exp_t  exp_q[$];
  logic [31:0] m_instret = '0;
  logic [1:0]  m_err = '0;
  bit          m_chk = 1'b1;

  int checks = 0, errors = 0, gcyc = 0;
  int n_cyc, rf_cnt, dreq_cnt, ireq_cnt, dwe_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int classify(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_LW:   return K_LD;
      OP_SW:   return K_ST;
      OP_BR:   return K_BR;
      OP_JAL:  return K_JAL;
      OP_JALR: return K_JALR;
      OP_ADDI, OP_ALU, OP_LUI, OP_AUIPC: return K_OTHER;
      OP_SYS:  return (f3 == 3'b000) ? K_SYS : K_ILL;
      default: return K_ILL;
    endcase
  endfunction

  // Append one cycle: current stimulus plus the outputs it must produce.
  task automatic push(input logic [2:0] st, input bit ireq, irwe, dreq, dwe, rfwe, pcwe,
                      input logic [1:0] psel);
    exp_t e;
    e.state = st; e.ireq = ireq; e.irwe = irwe; e.dreq = dreq; e.dwe = dwe;
    e.rfwe = rfwe; e.pcwe = pcwe; e.psel = psel; e.halted = (st == ST_HALT);
    e.err = m_err; e.instret = m_instret; e.chk = m_chk;
    stim_q.push_back(s_cur);
    exp_q.push_back(e);
    if (pcwe) m_instret++;
  endtask

  task automatic do_reset(input logic [2:0] cur, input bit chk);
    s_cur = '{default: 0};
    s_cur.rst = 1'b1;
    m_chk = chk;
    push(cur, 0, 0, 0, 0, 0, 0, 2'b00);
    m_chk = 1'b1;
    m_instret = '0;
    m_err = '0;
  endtask

  task automatic start_seq();
    s_cur = '{default: 0};
    push(ST_IDLE, 0, 0, 0, 0, 0, 0, 2'b00);
    s_cur.start = 1'b1;
    push(ST_IDLE, 0, 0, 0, 0, 0, 0, 2'b00);
  endtask

  task automatic halt_cycles(input int n);
    s_cur = '{default: 0};
    s_cur.start = 1'b1;
    for (int i = 0; i < n; i++) push(ST_HALT, 0, 0, 0, 0, 0, 0, 2'b00);
  endtask

  // Expand one instruction: iw/dw = low-ready cycles before the memory answers.
  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input int iw, input int dw,
                       input bit bt, input bit rst_mem);
    int  c;
    bit  st;
    c  = classify(op, f3);
    st = (c == K_ST);
    s_cur = '{default: 0};
    s_cur.op = op; s_cur.f3 = f3; s_cur.bt = bt;
    for (int k = 0; k < iw; k++) begin
      push(ST_FETCH, 1, 0, 0, 0, 0, 0, 2'b00);
      if (TO != 0 && k + 1 == TO) begin m_err = 2'b10; return; end
    end
    s_cur.imem_ready = 1'b1;
    push(ST_FETCH, 1, 1, 0, 0, 0, 0, 2'b00);
    s_cur.imem_ready = 1'b0;
    push(ST_DECODE, 0, 0, 0, 0, 0, 0, 2'b00);
    if (c == K_SYS) begin m_instret++; return; end
    if (c == K_ILL) begin m_err = 2'b01; return; end
    if (c == K_BR) begin
      push(ST_EXEC, 0, 0, 0, 0, 0, 1, bt ? 2'b01 : 2'b00);
      return;
    end
    push(ST_EXEC, 0, 0, 0, 0, 0, 0, 2'b00);
    if (c == K_LD || c == K_ST) begin
      for (int k = 0; k < dw; k++) begin
        if (rst_mem && k == 0) s_cur.rst = 1'b1;
        push(ST_MEM, 0, 0, 1, st, 0, 0, 2'b00);
        if (s_cur.rst) begin
          s_cur.rst = 1'b0; m_instret = '0; m_err = '0;
          return;
        end
        if (TO != 0 && k + 1 == TO) begin m_err = 2'b11; return; end
      end
      s_cur.dmem_ready = 1'b1;
      push(ST_MEM, 0, 0, 1, st, 0, st, 2'b00);
      s_cur.dmem_ready = 1'b0;
      if (st) return;
    end
    push(ST_WB, 0, 0, 0, 0, 1, 1, (c == K_JAL) ? 2'b10 : (c == K_JALR) ? 2'b11 : 2'b00);
  endtask

  task automatic play();
    stim_t s;
    exp_t  e;
    n_cyc = 0; rf_cnt = 0; dreq_cnt = 0; ireq_cnt = 0; dwe_cnt = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      rst = s.rst; start = s.start; imem_ready = s.imem_ready; dmem_ready = s.dmem_ready;
      branch_taken = s.bt; opcode = s.op; funct3 = s.f3;
      @(negedge clk);
      n_cyc++; gcyc++;
      rf_cnt += int'(rf_we); dreq_cnt += int'(dmem_req);
      ireq_cnt += int'(imem_req); dwe_cnt += int'(dmem_we);
      if (e.chk) begin
        check($sformatf("cyc%0d_outputs", gcyc),
              64'({state, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halted, err_code, instret}),
              64'({e.state, e.ireq, e.irwe, e.dreq, e.dwe, e.rfwe, e.pcwe, e.halted, e.err, e.instret}));
        if (e.pcwe || e.state == ST_IDLE)
          check($sformatf("cyc%0d_pc_sel", gcyc), 64'(pc_sel), 64'(e.psel));
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset values
    do_reset(ST_IDLE, 1'b0);
    play();
    check("rst_state", 64'(state), 64'(0));
    check("rst_instret", 64'(instret), 64'(0));
    check("rst_err", 64'(err_code), 64'(0));
    check("rst_strobes", 64'({imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halted, pc_sel}), 64'(0));

    // addi with zero-wait fetch
    start_seq();
    instr(OP_ADDI, 3'b000, 0, 0, 1'b0, 1'b0);
    play();
    check("addi_instret", 64'(instret), 64'(1));
    check("addi_rf_we_cycles", 64'(rf_cnt), 64'(1));
    check("addi_back_to_fetch", 64'(state), 64'(1));

    // lw: dmem_ready after 3 low cycles
    instr(OP_LW, 3'b010, 0, 3, 1'b0, 1'b0);
    play();
    check("lw_cycles", 64'(n_cyc), 64'(8));
    check("lw_dmem_req_cycles", 64'(dreq_cnt), 64'(4));
    check("lw_dmem_we_cycles", 64'(dwe_cnt), 64'(0));
    check("lw_instret", 64'(instret), 64'(2));

    // beq taken
    instr(OP_BR, 3'b000, 0, 0, 1'b1, 1'b0);
    play();
    check("beq_cycles", 64'(n_cyc), 64'(3));
    check("beq_rf_we_cycles", 64'(rf_cnt), 64'(0));
    check("beq_instret", 64'(instret), 64'(3));

    // Mixed classes; jal fetch ready arrives on the last permitted wait cycle
    instr(OP_JAL,   3'b000, 3, 0, 1'b0, 1'b0);
    instr(OP_JALR,  3'b000, 0, 0, 1'b0, 1'b0);
    instr(OP_SW,    3'b010, 0, 0, 1'b0, 1'b0);
    instr(OP_LUI,   3'b000, 1, 0, 1'b0, 1'b0);
    instr(OP_ALU,   3'b000, 0, 0, 1'b0, 1'b0);
    instr(OP_AUIPC, 3'b000, 0, 0, 1'b0, 1'b0);
    instr(OP_BR,    3'b001, 0, 0, 1'b0, 1'b0);
    play();
    check("mix_instret", 64'(instret), 64'(10));

    // Fetch timeout
    instr(OP_ADDI, 3'b000, 10, 0, 1'b0, 1'b0);
    halt_cycles(3);
    play();
    check("ito_imem_req_cycles", 64'(ireq_cnt), 64'(4));
    check("ito_err", 64'(err_code), 64'(2));
    check("ito_halted", 64'({halted, state}), 64'({1'b1, 3'd6}));
    check("ito_instret", 64'(instret), 64'(10));

    // ecall after two addi
    do_reset(ST_HALT, 1'b1);
    start_seq();
    instr(OP_ADDI, 3'b000, 0, 0, 1'b0, 1'b0);
    instr(OP_ADDI, 3'b000, 0, 0, 1'b0, 1'b0);
    instr(OP_SYS,  3'b000, 0, 0, 1'b0, 1'b0);
    halt_cycles(2);
    play();
    check("ecall_err", 64'(err_code), 64'(0));
    check("ecall_instret", 64'(instret), 64'(3));
    check("ecall_halted", 64'(halted), 64'(1));

    // Illegal opcode 7F
    do_reset(ST_HALT, 1'b1);
    start_seq();
    instr(7'h7F, 3'b000, 0, 0, 1'b0, 1'b0);
    halt_cycles(1);
    play();
    check("ill7f_err", 64'(err_code), 64'(1));
    check("ill7f_instret", 64'(instret), 64'(0));

    // SYSTEM opcode with funct3 != 0 is illegal
    do_reset(ST_HALT, 1'b1);
    start_seq();
    instr(OP_ADDI, 3'b000, 0, 0, 1'b0, 1'b0);
    instr(OP_SYS,  3'b001, 0, 0, 1'b0, 1'b0);
    halt_cycles(1);
    play();
    check("sysf3_err", 64'(err_code), 64'(1));
    check("sysf3_instret", 64'(instret), 64'(1));

    // Reset during sw MEM
    do_reset(ST_HALT, 1'b1);
    start_seq();
    instr(OP_ADDI, 3'b000, 0, 0, 1'b0, 1'b0);
    instr(OP_SW,   3'b010, 0, 2, 1'b0, 1'b1);
    s_cur = '{default: 0};
    push(ST_IDLE, 0, 0, 0, 0, 0, 0, 2'b00);
    play();
    check("rstmem_state", 64'(state), 64'(0));
    check("rstmem_dmem_req", 64'(dmem_req), 64'(0));
    check("rstmem_instret_err", 64'({instret, err_code}), 64'(0));

    // Data-memory timeout
    start_seq();
    instr(OP_LW, 3'b010, 0, 10, 1'b0, 1'b0);
    halt_cycles(2);
    play();
    check("dto_dmem_req_cycles", 64'(dreq_cnt), 64'(4));
    check("dto_err", 64'(err_code), 64'(3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
